// File: rtl/child_rr_arbiter.sv
// child_rr_arbiter: round-robin grant of one shared resource among N_REQ children, one turnaround cycle between owners.
// Optional hold watchdog enabled by defining CHILD_RR_ARBITER_WATCHDOG_EN.
module child_rr_arbiter #(
  parameter int N_REQ = 5,
  parameter int MAX_HOLD = 16,
  parameter int ID_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, win, nxt_ptr;
  logic [N_REQ-1:0] rot;
  logic [ID_W:0] off, sum;
  logic any, owner_req, limit;
  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || MAX_HOLD < 1) begin : g_bad_cfg
    $error("child_rr_arbiter: illegal parameters");
  end
  // rot[k] is req[(ptr+k) mod N_REQ]; the lowest set k is the winner's distance from ptr
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = N_REQ-1; k >= 0; k--) off = rot[k] ? (ID_W+1)'(k) : off;
    sum = {1'b0, ptr} + off;
    win = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : sum[ID_W-1:0];
  end
  assign any = |req;
  assign owner_req = |(req & gnt);
  assign nxt_ptr = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
`ifdef CHILD_RR_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(MAX_HOLD+1);
  logic [CW-1:0] hold_cnt;
  assign limit = hold_cnt == CW'(MAX_HOLD-1);
`else
  assign limit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      busy <= 1'b0;
`ifdef CHILD_RR_ARBITER_WATCHDOG_EN
      hold_cnt <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef CHILD_RR_ARBITER_WATCHDOG_EN
      timeout <= 1'b0;
      hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
`endif
      if (state == GRANT) begin
        if (!owner_req || limit) begin
          state <= GAP;
          gnt <= '0;
          gnt_valid <= 1'b0;
          gnt_id <= '0;
          ptr <= nxt_ptr;
`ifdef CHILD_RR_ARBITER_WATCHDOG_EN
          timeout <= owner_req;
`endif
        end
      end else if (any) begin
        state <= GRANT;
        gnt <= N_REQ'(1) << win;
        gnt_valid <= 1'b1;
        gnt_id <= win;
        busy <= 1'b1;
      end else begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_child_rr_arbiter.sv
// tb_child_rr_arbiter: directed scoreboard bench for child_rr_arbiter (N_REQ=5, MAX_HOLD=4).
module tb_child_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] gnt;
  logic gnt_valid, busy, timeout;
  logic [2:0] gnt_id;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [4:0] g;
    logic b;
    logic t;
    string tag;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  child_rr_arbiter #(.N_REQ(5), .MAX_HOLD(4), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] oh2id(input logic [4:0] v);
    oh2id = 3'd0;
    for (int i = 0; i < 5; i++) if (v[i]) oh2id = 3'(i);
  endfunction
  task automatic step(input logic [4:0] r, input logic [4:0] eg, input logic eb, input logic et, input string tag);
    exp_t e;
    req = r;
    sb.push_back('{eg, eb, et, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " gnt"}, 8'(gnt), 8'(e.g));
    chk({e.tag, " gnt_valid"}, 8'(gnt_valid), 8'(|e.g));
    chk({e.tag, " gnt_id"}, 8'(gnt_id), 8'(oh2id(e.g)));
    chk({e.tag, " busy"}, 8'(busy), 8'(e.b));
    chk({e.tag, " timeout"}, 8'(timeout), 8'(e.t));
    chk({e.tag, " onehot"}, 8'($onehot0(gnt)), 8'd1);
  endtask
  task automatic g(input logic [4:0] r, input logic [4:0] eg, input string tag);
    step(r, eg, 1'b1, 1'b0, tag);
  endtask
  task automatic gap(input logic [4:0] r, input string tag);
    step(r, 5'b0, 1'b1, 1'b0, tag);
  endtask
  task automatic idle(input string tag);
    step(5'b0, 5'b0, 1'b0, 1'b0, tag);
  endtask
  initial begin
    logic [4:0] o, n;
    #12;
    chk("rst gnt", 8'(gnt), 8'd0);
    chk("rst gnt_valid", 8'(gnt_valid), 8'd0);
    chk("rst gnt_id", 8'(gnt_id), 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst timeout", 8'(timeout), 8'd0);
    rst_n = 1'b1;
    // full rotation with every child requesting, ptr starts at 0
    g(5'b11111, 5'b00001, "rot");
    for (int i = 0; i < 5; i++) begin
      o = 5'(1 << i);
      n = 5'(1 << ((i + 1) % 5));
      g(5'b11111, o, "rot hold");
      g(5'b11111, o, "rot hold");
      gap(5'b11111 & ~o, "rot gap");
      g(5'b11111, n, "rot next");
    end
    gap(5'b0, "rot end gap");
    idle("rot end idle");
    // single child holding for four cycles
    repeat (4) g(5'b00100, 5'b00100, "single");
    gap(5'b0, "single gap");
    idle("single idle");
    // wrap-around: release child 3 leaves ptr=4
    g(5'b01000, 5'b01000, "wrap c3");
    gap(5'b0, "wrap gap");
    idle("wrap idle");
    g(5'b00011, 5'b00001, "wrap c0");
    gap(5'b0, "wrap gap2");
    idle("wrap idle2");
    g(5'b10001, 5'b10000, "wrap c4");
    g(5'b10001, 5'b10000, "wrap c4 hold");
    gap(5'b00001, "wrap gap3");
    g(5'b00001, 5'b00001, "wrap c0 after c4");
    gap(5'b0, "wrap gap4");
    idle("wrap idle4");
    // asynchronous reset in the middle of a grant
    g(5'b00100, 5'b00100, "async pre");
    #3 rst_n = 1'b0;
    #1;
    chk("async gnt", 8'(gnt), 8'd0);
    chk("async gnt_valid", 8'(gnt_valid), 8'd0);
    chk("async busy", 8'(busy), 8'd0);
    #2 rst_n = 1'b1;
    g(5'b00110, 5'b00010, "async lowest");
    gap(5'b0, "async gap");
    idle("async idle");
`ifdef CHILD_RR_ARBITER_WATCHDOG_EN
    repeat (4) g(5'b00010, 5'b00010, "wd hold");
    step(5'b00110, 5'b0, 1'b1, 1'b1, "wd timeout");
    g(5'b00110, 5'b00100, "wd next");
`else
    repeat (120) g(5'b00010, 5'b00010, "long hold");
`endif
    gap(5'b0, "hold gap");
    idle("hold idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
